// File: rtl/pulse_transmitter_symbol_sequencer.sv
// Symbol sequencer: plays programmed {level, psel, duration} symbols through the countdown timer.
// Optional multi-pass playback is enabled with `define PULSE_TRANSMITTER_SEQ_LOOP_EN.
module pulse_transmitter_symbol_sequencer #(
  parameter int NUM_SYMBOLS     = 8,
  parameter int TIMER_WIDTH     = 8,
  parameter int PRESCALER_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               sys_rst_n,
  input  logic                               sym_we,
  input  logic [$clog2(NUM_SYMBOLS)-1:0]     sym_addr,
  input  logic [TIMER_WIDTH+1:0]             sym_wdata,
  input  logic [$clog2(NUM_SYMBOLS):0]       cfg_length,
  input  logic                               cfg_idle_level,
  input  logic [$clog2(PRESCALER_WIDTH)-1:0] cfg_prescaler0,
  input  logic [$clog2(PRESCALER_WIDTH)-1:0] cfg_prescaler1,
  input  logic [7:0]                         cfg_loop_count,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               timer_pulse,
  output logic                               timer_en,
  output logic [$clog2(PRESCALER_WIDTH)-1:0] timer_prescaler,
  output logic [TIMER_WIDTH-1:0]             timer_duration,
  output logic                               pulse_out,
  output logic                               busy,
  output logic                               done
);

  localparam int AW = $clog2(NUM_SYMBOLS);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(PRESCALER_WIDTH);
  localparam int DW = TIMER_WIDTH + 2;
  localparam logic [LW-1:0] MAX_LEN = LW'(NUM_SYMBOLS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                 state, state_next;
  logic [DW-1:0]          mem [NUM_SYMBOLS];
  logic [AW-1:0]          idx, idx_next;
  logic [LW-1:0]          len, len_next;
  logic [LW-1:0]          eff_len;
  logic                   last_sym;
  logic                   capture;
  logic [AW-1:0]          cap_idx;
  logic [DW-1:0]          cap_entry;
  logic                   en_next;
  logic [PW-1:0]          pre_next;
  logic [TIMER_WIDTH-1:0] dur_next;
  logic                   pout_next;
  logic                   done_next;

`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
  logic [7:0] pass_cnt, pass_next;
`else
  logic unused_loop_count;
  assign unused_loop_count = ^cfg_loop_count;
`endif

  assign eff_len  = (cfg_length > MAX_LEN) ? MAX_LEN : cfg_length;
  assign last_sym = ({1'b0, idx} == (len - LW'(1)));
  assign busy     = (state == LOAD) || (state == RUN);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_SYMBOLS; i++) mem[i] <= '0;
    end else if (sym_we) begin
      mem[sym_addr] <= sym_wdata;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      len             <= '0;
      timer_en        <= 1'b0;
      timer_prescaler <= '0;
      timer_duration  <= '0;
      pulse_out       <= 1'b0;
      done            <= 1'b0;
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
      pass_cnt        <= '0;
`endif
    end else begin
      state           <= state_next;
      idx             <= idx_next;
      len             <= len_next;
      timer_en        <= en_next;
      timer_prescaler <= pre_next;
      timer_duration  <= dur_next;
      pulse_out       <= pout_next;
      done            <= done_next;
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
      pass_cnt        <= pass_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    len_next   = len;
    en_next    = timer_en;
    pre_next   = timer_prescaler;
    dur_next   = timer_duration;
    pout_next  = pulse_out;
    done_next  = 1'b0;
    capture    = 1'b0;
    cap_idx    = idx;
    cap_entry  = '0;
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
    pass_next  = pass_cnt;
`endif

    case (state)
      IDLE: begin
        en_next   = 1'b0;
        pout_next = cfg_idle_level;
        if (start) begin
          if (eff_len != '0) begin
            state_next = LOAD;
            idx_next   = '0;
            len_next   = eff_len;
            capture    = 1'b1;
            cap_idx    = '0;
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
            pass_next  = cfg_loop_count;
`endif
          end else begin
            done_next = 1'b1;
          end
        end
      end
      LOAD: begin
        state_next = RUN;
        en_next    = 1'b1;
      end
      RUN: begin
        en_next = 1'b1;
        if (timer_pulse) begin
          en_next = 1'b0;
          if (!last_sym) begin
            state_next = LOAD;
            idx_next   = idx + AW'(1);
            capture    = 1'b1;
            cap_idx    = idx + AW'(1);
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
          end else if (pass_cnt != 8'd0) begin
            state_next = LOAD;
            idx_next   = '0;
            pass_next  = pass_cnt - 8'd1;
            capture    = 1'b1;
            cap_idx    = '0;
`endif
          end else begin
            state_next = DONE;
            pout_next  = cfg_idle_level;
            done_next  = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        en_next    = 1'b0;
        pout_next  = cfg_idle_level;
      end
      default: state_next = IDLE;
    endcase

    // Forward a same-cycle write so a symbol rewritten just before capture still plays its new value.
    if (capture) begin
      cap_entry = (sym_we && (sym_addr == cap_idx)) ? sym_wdata : mem[cap_idx];
      dur_next  = cap_entry[TIMER_WIDTH-1:0];
      pre_next  = cap_entry[DW-2] ? cfg_prescaler1 : cfg_prescaler0;
      pout_next = cap_entry[DW-1];
    end

    if (stop) begin
      state_next = IDLE;
      en_next    = 1'b0;
      pout_next  = cfg_idle_level;
      done_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// Directed bench for pulse_transmitter_symbol_sequencer; the bench plays the role of the countdown timer.
module tb_pulse_transmitter_symbol_sequencer;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       sym_we;
  logic [2:0] sym_addr;
  logic [9:0] sym_wdata;
  logic [3:0] cfg_length;
  logic       cfg_idle_level;
  logic [3:0] cfg_prescaler0;
  logic [3:0] cfg_prescaler1;
  logic [7:0] cfg_loop_count;
  logic       start;
  logic       stop;
  logic       timer_pulse;
  logic       timer_en;
  logic [3:0] timer_prescaler;
  logic [7:0] timer_duration;
  logic       pulse_out;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  logic [7:0] seen_dur [$];

  pulse_transmitter_symbol_sequencer dut (
    .clk             (clk),
    .sys_rst_n       (sys_rst_n),
    .sym_we          (sym_we),
    .sym_addr        (sym_addr),
    .sym_wdata       (sym_wdata),
    .cfg_length      (cfg_length),
    .cfg_idle_level  (cfg_idle_level),
    .cfg_prescaler0  (cfg_prescaler0),
    .cfg_prescaler1  (cfg_prescaler1),
    .cfg_loop_count  (cfg_loop_count),
    .start           (start),
    .stop            (stop),
    .timer_pulse     (timer_pulse),
    .timer_en        (timer_en),
    .timer_prescaler (timer_prescaler),
    .timer_duration  (timer_duration),
    .pulse_out       (pulse_out),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       tpulse;
    logic       we;
    logic [2:0] addr;
    logic [9:0] wdata;
    logic [3:0] len;
    logic       en;
    logic [3:0] pre;
    logic [7:0] dur;
    logic       pout;
    logic       bsy;
    logic       dn;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start       = v.start;
    stop        = v.stop;
    timer_pulse = v.tpulse;
    sym_we      = v.we;
    sym_addr    = v.addr;
    sym_wdata   = v.wdata;
    cfg_length  = v.len;
    step();
  endtask

  task automatic clearInputs();
    start = 1'b0; stop = 1'b0; timer_pulse = 1'b0; sym_we = 1'b0;
    sym_addr = '0; sym_wdata = '0;
  endtask

  // Starts a program and answers every enabled timer cycle with a pulse, logging each LOAD's duration.
  task automatic playProgram(input logic [3:0] len, output int nsym, output int ndone);
    int cyc;
    nsym  = 0;
    ndone = 0;
    seen_dur.delete();
    cfg_length = len;
    start = 1'b1;
    step();
    start = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (busy && !timer_en) begin
        nsym++;
        seen_dur.push_back(timer_duration);
      end
      if (done) ndone++;
      if (!busy && !done) break;
      timer_pulse = timer_en;
      step();
    end
    timer_pulse = 1'b0;
    if (cyc >= 300) begin
      checks++;
      failures++;
      $display("[TB] FAIL play_timeout actual=%0d expected=<300 cycles", cyc);
    end
  endtask

  vec_t vecs [13];

  initial begin
    int nsym, ndone, extra;
    int exp_n;

    vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,3'd0,10'h203,4'd2, 1'b0,4'd0,8'd0,1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,3'd1,10'h105,4'd2, 1'b0,4'd0,8'd0,1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,3'd0,10'h000,4'd2, 1'b0,4'd0,8'd3,1'b1,1'b1,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,3'd0,10'h000,4'd2, 1'b1,4'd0,8'd3,1'b1,1'b1,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,3'd0,10'h000,4'd2, 1'b1,4'd0,8'd3,1'b1,1'b1,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,3'd0,10'h000,4'd2, 1'b0,4'd2,8'd5,1'b0,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,3'd0,10'h000,4'd2, 1'b1,4'd2,8'd5,1'b0,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,3'd0,10'h000,4'd2, 1'b0,4'd0,8'd0,1'b1,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,3'd0,10'h000,4'd2, 1'b0,4'd0,8'd0,1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,3'd0,10'h000,4'd2, 1'b0,4'd0,8'd0,1'b1,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,3'd0,10'h000,4'd0, 1'b0,4'd0,8'd0,1'b1,1'b0,1'b1};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,3'd0,10'h000,4'd0, 1'b0,4'd0,8'd0,1'b1,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b1,1'b0,1'b0,3'd0,10'h000,4'd2, 1'b0,4'd0,8'd0,1'b1,1'b0,1'b0};

    clearInputs();
    cfg_length     = 4'd0;
    cfg_idle_level = 1'b1;
    cfg_prescaler0 = 4'd0;
    cfg_prescaler1 = 4'd2;
    cfg_loop_count = 8'd2;
    sys_rst_n      = 1'b0;
    step();
    step();
    checkOutput("rst_en",   timer_en, 0);
    checkOutput("rst_pout", pulse_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pre",  timer_prescaler, 0);
    checkOutput("rst_dur",  timer_duration, 0);
    sys_rst_n = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_en", i),   timer_en,  vecs[i].en);
      checkOutput($sformatf("v%0d_pout", i), pulse_out, vecs[i].pout);
      checkOutput($sformatf("v%0d_busy", i), busy,      vecs[i].bsy);
      checkOutput($sformatf("v%0d_done", i), done,      vecs[i].dn);
      if (vecs[i].bsy) begin
        checkOutput($sformatf("v%0d_pre", i), timer_prescaler, vecs[i].pre);
        checkOutput($sformatf("v%0d_dur", i), timer_duration,  vecs[i].dur);
      end
    end
    clearInputs();

    // Eight distinct symbols, then a length larger than the memory.
    for (int i = 0; i < 8; i++) begin
      sym_we    = 1'b1;
      sym_addr  = 3'(i);
      sym_wdata = {i[0], 1'b0, 8'(10 + i)};
      step();
    end
    clearInputs();
    playProgram(4'd12, nsym, ndone);
    checkOutput("len12_symbols", nsym, 8);
    checkOutput("len12_done", ndone, 1);
    for (int i = 0; i < 8; i++)
      if (i < seen_dur.size()) checkOutput($sformatf("len12_dur%0d", i), seen_dur[i], 10 + i);

`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
    exp_n = 9;
`else
    exp_n = 3;
`endif
    cfg_loop_count = 8'd2;
    playProgram(4'd3, nsym, ndone);
    checkOutput("loop_symbols", nsym, exp_n);
    checkOutput("loop_done", ndone, 1);
    for (int i = 0; i < exp_n; i++)
      if (i < seen_dur.size()) checkOutput($sformatf("loop_dur%0d", i), seen_dur[i], 10 + (i % 3));
    cfg_loop_count = 8'd0;

    // Abort during symbol 1 with pulse and start in the same cycle.
    cfg_length = 4'd3;
    start = 1'b1; step(); start = 1'b0;
    step();
    timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
    step();
    checkOutput("stop_pre_dur", timer_duration, 11);
    stop = 1'b1; timer_pulse = 1'b1; start = 1'b1;
    step();
    clearInputs();
    checkOutput("stop_en",   timer_en, 0);
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_done", done, 0);
    checkOutput("stop_pout", pulse_out, 1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      timer_pulse = timer_en;
      step();
      if (busy || done) extra++;
    end
    timer_pulse = 1'b0;
    checkOutput("stop_quiet", extra, 0);

    // Rewrite symbol 2 while symbol 1 is running.
    start = 1'b1; step(); start = 1'b0;
    step();
    timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
    step();
    sym_we = 1'b1; sym_addr = 3'd2; sym_wdata = {1'b1, 1'b1, 8'd77};
    step();
    sym_we = 1'b0;
    checkOutput("wr_still_run", timer_en, 1);
    timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
    checkOutput("wr_dur",  timer_duration, 77);
    checkOutput("wr_pre",  timer_prescaler, 2);
    checkOutput("wr_pout", pulse_out, 1);
    checkOutput("wr_en",   timer_en, 0);
    step();
    timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
    checkOutput("wr_done", done, 1);
    step();

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; step(); start = 1'b0;
    step();
    checkOutput("arst_pre_en", timer_en, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("arst_en",   timer_en, 0);
    checkOutput("arst_pout", pulse_out, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    step();
    sys_rst_n = 1'b1;
    step();
    cfg_prescaler0 = 4'd3;
    cfg_length = 4'd1;
    start = 1'b1; step(); start = 1'b0;
    checkOutput("arst_mem_dur",  timer_duration, 0);
    checkOutput("arst_mem_pre",  timer_prescaler, 3);
    checkOutput("arst_mem_pout", pulse_out, 0);
    checkOutput("arst_mem_busy", busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_transmitter_symbol_sequencer.md
Name: pulse_transmitter_symbol_sequencer

Overview:
Plays a short programmed sequence of output symbols on the transmitter pin. Each symbol is an output level held for one countdown-timer period. The block owns the symbol memory and a small FSM, and drives the pulse_transmitter_countdown_timer through its en/prescaler/duration inputs, advancing on its pulse_out. It sits between the host register interface and the timer/output pin.

Parameters:
NUM_SYMBOLS, 8, symbol memory depth (power of 2, >=2)
TIMER_WIDTH, 8, duration field width; matches the timer's TIMER_WIDTH
PRESCALER_WIDTH, 16, matches the timer's PRESCALER_WIDTH; select width is $clog2(PRESCALER_WIDTH)

Ports:
clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
sym_we  in  1  symbol memory write strobe
sym_addr  in  $clog2(NUM_SYMBOLS)  write address
sym_wdata  in  TIMER_WIDTH+2  {level, psel, duration}
cfg_length  in  $clog2(NUM_SYMBOLS)+1  number of symbols in program
cfg_idle_level  in  1  pin level when not playing
cfg_prescaler0  in  $clog2(PRESCALER_WIDTH)  prescaler used when psel=0
cfg_prescaler1  in  $clog2(PRESCALER_WIDTH)  prescaler used when psel=1
cfg_loop_count  in  8  extra passes (used only with the optional feature)
start  in  1  1-cycle start command
stop  in  1  1-cycle abort command
timer_pulse  in  1  timer pulse_out
timer_en  out  1  timer enable
timer_prescaler  out  $clog2(PRESCALER_WIDTH)  timer prescaler
timer_duration  out  TIMER_WIDTH  timer duration
pulse_out  out  1  transmitter pin level
busy  out  1  high in LOAD or RUN
done  out  1  1-cycle completion strobe

Behaviour:
- Reset (async): FSM=IDLE; symbol memory, idx, pass counter all 0; timer_en=0, timer_prescaler=0, timer_duration=0, pulse_out=0, busy=0, done=0. Outputs are registered.
- Symbol memory: written on any cycle with sym_we. A write to an entry not yet captured in the current pass takes effect in that pass.
- IDLE: timer_en=0, pulse_out=cfg_idle_level (registered, 1-cycle lag). start with effective length != 0 -> LOAD with idx=0. Effective length = min(cfg_length, NUM_SYMBOLS). start with effective length 0 -> done pulses, stay IDLE.
- Entering LOAD, captured from mem[idx]:
  - timer_duration <= duration
  - timer_prescaler <= psel ? cfg_prescaler1 : cfg_prescaler0
  - pulse_out <= level
  - timer_en stays 0, which meets the timer rule that values precede en by 1 cycle.
- LOAD lasts exactly 1 cycle, then -> RUN.
- RUN: timer_en=1; outputs held stable. On the first timer_pulse seen in RUN:
  - idx < length-1: idx++, -> LOAD. timer_en drops for one cycle, which restarts the timer.
  - idx == length-1, last pass: -> DONE.
  - idx == length-1, passes remaining (feature only): idx=0, -> LOAD.
- DONE: 1 cycle; done=1, timer_en=0, pulse_out<=cfg_idle_level; then -> IDLE.
- timer_pulse outside RUN: ignored.
- start while busy: ignored. stop in any state: next cycle IDLE, timer_en=0, pulse_out<=cfg_idle_level, no done.
- start and stop in the same cycle: stop wins.
- cfg_* values are sampled at start (length, loop count) or at LOAD (prescalers). Changes mid-RUN do not affect the current symbol.
- busy = (state==LOAD || state==RUN).

Optional Feature:
PULSE_TRANSMITTER_SEQ_LOOP_EN
- Defined: an 8-bit pass counter is loaded from cfg_loop_count at start. The program plays cfg_loop_count+1 times back to back: after the last symbol, idx wraps to 0 via LOAD, with no idle gap other than the LOAD cycle. done fires once, after the final pass. stop aborts any pass.
- Undefined: cfg_loop_count is ignored (port kept, unconnected internally); exactly one pass is played.

Test Plan:
- Reset mid-RUN: assert sys_rst_n=0 asynchronously -> timer_en, pulse_out, busy, done all 0 immediately.
- Program mem0={1,0,3}, mem1={0,1,5}, cfg_prescaler1=2, length=2, start -> mem0 phase:
  - LOAD cycle shows duration=3, prescaler=0, pulse_out=1, en=0; then en=1.
  - On timer_pulse: one en=0 cycle, then duration=5, prescaler=2, pulse_out=0.
  - Next timer_pulse -> done=1 for 1 cycle, pulse_out=idle.
- length=0 or length=12 with NUM_SYMBOLS=8 -> length=0 gives done without busy; length=12 plays exactly 8 symbols.
- stop asserted in RUN of symbol 1 (same cycle as timer_pulse and start) -> next cycle IDLE, timer_en=0, no done, no further symbols.
- sym_we to idx 2 while symbol 1 is running -> symbol 2 plays the new value.
- With the macro defined, cfg_loop_count=2, length=3 -> 9 symbols played (0,1,2,0,1,2,0,1,2), one done. Without the macro, same config -> 3 symbols played.
